// File: rtl/dl11_console.sv
// DL11-compatible console registers (RCSR/RBUF/XCSR/XBUF) fronting the async uart block.
// Define DL11_INTR_EN to generate rx/tx interrupt requests; otherwise both are tied low.
module dl11_console #(
  parameter logic [12:0] BASE = 13'o17560
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] iopage_addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  input  logic        iopage_rd,
  input  logic        iopage_wr,
  input  logic        iopage_byte_op,
  output logic        decode,
  output logic        ld_tx_data,
  output logic [7:0]  tx_data,
  input  logic        tx_empty,
  output logic        uld_rx_data,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic        tx_enable,
  output logic        rx_enable,
  output logic        rx_int_req,
  output logic        tx_int_req,
  input  logic        rx_int_ack,
  input  logic        tx_int_ack
);

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_LOAD = 2'd1;
  localparam logic [1:0] T_BUSY = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_UNLD = 2'd1;
  localparam logic [1:0] R_CAP  = 2'd2;

  logic [1:0] offset;
  logic       wr_hit;
  logic       xbuf_wr;
  logic       rbuf_rd;
  logic       ready;
  logic       tx_e_m, tx_e_s;
  logic       rx_e_m, rx_e_s;
  logic [1:0] tx_state, tx_state_d;
  logic [1:0] rx_state, rx_state_d;
  logic       rx_ie, tx_ie;
  logic       done, ovr;
  logic [7:0] rbuf;
  logic       enable;
  logic       unused_data;

  assign decode      = (iopage_addr[12:3] == BASE[12:3]);
  assign offset      = iopage_addr[2:1];
  // High-byte writes are dropped; a low-byte write acts as a word write of that byte.
  assign wr_hit      = iopage_wr & decode & ~(iopage_byte_op & iopage_addr[0]);
  assign xbuf_wr     = wr_hit & (offset == 2'd3);
  assign rbuf_rd     = iopage_rd & decode & (offset == 2'd1);
  assign ready       = (tx_state == T_IDLE);
  assign ld_tx_data  = (tx_state == T_LOAD);
  assign uld_rx_data = (rx_state == R_UNLD);
  assign tx_enable   = enable;
  assign rx_enable   = enable;
  assign unused_data = ^data_in[15:8];

  // Two-flop synchronizers; idle (empty) is the safe reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_e_m <= 1'b1;
      tx_e_s <= 1'b1;
      rx_e_m <= 1'b1;
      rx_e_s <= 1'b1;
    end else begin
      tx_e_m <= tx_empty;
      tx_e_s <= tx_e_m;
      rx_e_m <= rx_empty;
      rx_e_s <= rx_e_m;
    end
  end

  always_comb begin
    tx_state_d = tx_state;
    case (tx_state)
      T_IDLE:  if (xbuf_wr) tx_state_d = T_LOAD;
      T_LOAD:  if (!tx_e_s) tx_state_d = T_BUSY;
      T_BUSY:  if (tx_e_s) tx_state_d = T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state;
    case (rx_state)
      R_IDLE:  if (!rx_e_s) rx_state_d = R_UNLD;
      R_UNLD:  if (rx_e_s) rx_state_d = R_CAP;
      R_CAP:   rx_state_d = R_IDLE;
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= T_IDLE;
      rx_state <= R_IDLE;
      tx_data  <= 8'h00;
      rx_ie    <= 1'b0;
      tx_ie    <= 1'b0;
      done     <= 1'b0;
      ovr      <= 1'b0;
      rbuf     <= 8'h00;
      enable   <= 1'b0;
    end else begin
      tx_state <= tx_state_d;
      rx_state <= rx_state_d;
      enable   <= 1'b1;
      if (xbuf_wr && ready) tx_data <= data_in[7:0];
      if (wr_hit && offset == 2'd0) rx_ie <= data_in[6];
      if (wr_hit && offset == 2'd2) tx_ie <= data_in[6];
      // Capture beats a coincident RBUF read so the new byte is never lost.
      if (rx_state == R_CAP) begin
        rbuf <= rx_data;
        done <= 1'b1;
        if (done) ovr <= 1'b1;
      end else if (rbuf_rd) begin
        done <= 1'b0;
        ovr  <= 1'b0;
      end
    end
  end

  always_comb begin
    data_out = 16'h0000;
    if (decode && !reset) begin
      case (offset)
        2'd0:    data_out[7:6] = {done, rx_ie};
        2'd1:    data_out = {ovr, ovr, 6'b000000, rbuf};
        2'd2:    data_out[7:6] = {ready, tx_ie};
        default: data_out = 16'h0000;
      endcase
    end
  end

`ifdef DL11_INTR_EN
  logic rx_cond, tx_cond;
  logic rx_cond_q, tx_cond_q;

  assign rx_cond = rx_ie & done;
  assign tx_cond = tx_ie & ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cond_q  <= 1'b0;
      tx_cond_q  <= 1'b0;
      rx_int_req <= 1'b0;
      tx_int_req <= 1'b0;
    end else begin
      rx_cond_q  <= rx_cond;
      tx_cond_q  <= tx_cond;
      rx_int_req <= (rx_cond & ~rx_cond_q) | (rx_int_req & rx_cond & ~rx_int_ack);
      tx_int_req <= (tx_cond & ~tx_cond_q) | (tx_int_req & tx_cond & ~tx_int_ack);
    end
  end
`else
  logic unused_ack;

  assign unused_ack = rx_int_ack | tx_int_ack;
  assign rx_int_req = 1'b0;
  assign tx_int_req = 1'b0;
`endif

endmodule

// File: tb/tb_dl11_console.sv
// Bench for dl11_console: a clk-rate uart stand-in with loopback, a behavioural model checked
// every cycle, plus directed literal checks. Honours DL11_INTR_EN like the design.
module tb_dl11_console;

  localparam logic [12:0] BASE   = 13'o17560;
  localparam logic [12:0] A_RCSR = 13'o17560;
  localparam logic [12:0] A_RBUF = 13'o17562;
  localparam logic [12:0] A_XCSR = 13'o17564;
  localparam logic [12:0] A_XBUF = 13'o17566;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [12:0] iopage_addr = 13'd0;
  logic [15:0] data_in = 16'd0;
  logic [15:0] data_out;
  logic        iopage_rd = 1'b0;
  logic        iopage_wr = 1'b0;
  logic        iopage_byte_op = 1'b0;
  logic        decode;
  logic        ld_tx_data;
  logic [7:0]  tx_data;
  logic        tx_empty = 1'b1;
  logic        uld_rx_data;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_empty = 1'b1;
  logic        tx_enable, rx_enable;
  logic        rx_int_req, tx_int_req;
  logic        rx_int_ack = 1'b0;
  logic        tx_int_ack = 1'b0;

  int tests = 0;
  int fails = 0;

  dl11_console dut (
    .clk            (clk),
    .reset          (reset),
    .iopage_addr    (iopage_addr),
    .data_in        (data_in),
    .data_out       (data_out),
    .iopage_rd      (iopage_rd),
    .iopage_wr      (iopage_wr),
    .iopage_byte_op (iopage_byte_op),
    .decode         (decode),
    .ld_tx_data     (ld_tx_data),
    .tx_data        (tx_data),
    .tx_empty       (tx_empty),
    .uld_rx_data    (uld_rx_data),
    .rx_data        (rx_data),
    .rx_empty       (rx_empty),
    .tx_enable      (tx_enable),
    .rx_enable      (rx_enable),
    .rx_int_req     (rx_int_req),
    .tx_int_req     (tx_int_req),
    .rx_int_ack     (rx_int_ack),
    .tx_int_ack     (tx_int_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- uart stand-in (txclk = rxclk = clk, driven on negedge) ----------------
  logic [7:0] deliver_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] tx_byte;
  int         tx_cnt = 0;
  int         rx_quiet = 0;

  always @(negedge clk) begin
    if (reset) begin
      tx_empty = 1'b1;
      rx_empty = 1'b1;
      rx_data  = 8'd0;
      tx_cnt   = 0;
      rx_quiet = 0;
      deliver_q.delete();
      sent_q.delete();
    end else begin
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          tx_empty = 1'b1;
          deliver_q.push_back(tx_byte);
        end
      end else if (tx_empty && ld_tx_data) begin
        tx_empty = 1'b0;
        tx_byte  = tx_data;
        sent_q.push_back(tx_data);
        tx_cnt   = int'($urandom_range(6, 12));
      end
      if (!rx_empty && uld_rx_data) begin
        rx_empty = 1'b1;
        rx_quiet = 0;
      end else if (rx_empty) begin
        if (rx_quiet < 8) rx_quiet++;
        else if (deliver_q.size() > 0) begin
          rx_data  = deliver_q.pop_front();
          rx_empty = 1'b0;
        end
      end
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  logic       m_te1, m_te2, m_re1, m_re2;
  logic       m_ready, m_loading, m_unld, m_cap;
  logic       m_done, m_ovr, m_rie, m_tie, m_en;
  logic       m_rreq, m_treq, m_rc_prev, m_tc_prev;
  logic [7:0] m_txd, m_rbuf;
  logic       md_dec, md_wr, md_rbuf_rd, md_rc, md_tc;
  logic [1:0] md_off;
  logic [15:0] e_do;
  logic [30:0] e_vec, a_vec;

  always @(posedge clk) begin
    if (reset) begin
      m_te1 = 1; m_te2 = 1; m_re1 = 1; m_re2 = 1;
      m_ready = 1; m_loading = 0; m_unld = 0; m_cap = 0;
      m_done = 0; m_ovr = 0; m_rie = 0; m_tie = 0; m_en = 0;
      m_rreq = 0; m_treq = 0; m_rc_prev = 0; m_tc_prev = 0;
      m_txd = 8'd0; m_rbuf = 8'd0;
    end else begin
      md_dec     = (iopage_addr[12:3] == BASE[12:3]);
      md_off     = iopage_addr[2:1];
      md_wr      = iopage_wr && md_dec && !(iopage_byte_op && iopage_addr[0]);
      md_rbuf_rd = iopage_rd && md_dec && (md_off == 2'd1);
      md_rc      = m_rie && m_done;
      md_tc      = m_tie && m_ready;
`ifdef DL11_INTR_EN
      if (md_rc && !m_rc_prev) m_rreq = 1;
      else if (rx_int_ack || !md_rc) m_rreq = 0;
      if (md_tc && !m_tc_prev) m_treq = 1;
      else if (tx_int_ack || !md_tc) m_treq = 0;
      m_rc_prev = md_rc;
      m_tc_prev = md_tc;
`endif
      // transmit: byte handed over while loading, then wait for the uart to drain
      if (m_loading) begin
        if (!m_te2) m_loading = 0;
      end else if (!m_ready) begin
        if (m_te2) m_ready = 1;
      end else if (md_wr && md_off == 2'd3) begin
        m_loading = 1;
        m_ready   = 0;
        m_txd     = data_in[7:0];
      end
      // receive
      if (m_cap) begin
        m_rbuf = rx_data;
        if (m_done) m_ovr = 1;
        m_done = 1;
        m_cap  = 0;
      end else begin
        if (md_rbuf_rd) begin
          m_done = 0;
          m_ovr  = 0;
        end
        if (m_unld) begin
          if (m_re2) begin
            m_unld = 0;
            m_cap  = 1;
          end
        end else if (!m_re2) begin
          m_unld = 1;
        end
      end
      if (md_wr && md_off == 2'd0) m_rie = data_in[6];
      if (md_wr && md_off == 2'd2) m_tie = data_in[6];
      m_te2 = m_te1; m_te1 = tx_empty;
      m_re2 = m_re1; m_re1 = rx_empty;
      m_en  = 1;
    end
    #2;
    e_do = 16'd0;
    if (!reset && iopage_addr[12:3] == BASE[12:3]) begin
      case (iopage_addr[2:1])
        2'd0: e_do = (m_done ? 16'd128 : 16'd0) + (m_rie ? 16'd64 : 16'd0);
        2'd1: e_do = (m_ovr ? 16'hC000 : 16'h0000) | {8'd0, m_rbuf};
        2'd2: e_do = (m_ready ? 16'd128 : 16'd0) + (m_tie ? 16'd64 : 16'd0);
        default: e_do = 16'd0;
      endcase
    end
    e_vec = {e_do, (iopage_addr[12:3] == BASE[12:3]), m_loading, m_txd, m_unld,
             m_en, m_en, m_rreq, m_treq};
    a_vec = {data_out, decode, ld_tx_data, tx_data, uld_rx_data,
             tx_enable, rx_enable, rx_int_req, tx_int_req};
    tests++;
    if (a_vec !== e_vec) begin
      fails++;
      if (fails < 30) $display("FAIL cycle_model @%0t: got %h, expected %h", $time, a_vec, e_vec);
    end
  end

  // ---------------- bus helpers ----------------
  task automatic rd(input logic [12:0] a, output logic [15:0] v);
    @(negedge clk);
    iopage_addr = a; iopage_byte_op = 1'b0; iopage_rd = 1'b1;
    #1 v = data_out;
    @(negedge clk);
    iopage_rd = 1'b0;
  endtask

  task automatic wr(input logic [12:0] a, input logic [15:0] d, input logic bop);
    @(negedge clk);
    iopage_addr = a; data_in = d; iopage_byte_op = bop; iopage_wr = 1'b1;
    @(negedge clk);
    iopage_wr = 1'b0; iopage_byte_op = 1'b0;
  endtask

  task automatic rd_check(input logic [12:0] a, input logic [15:0] exp, input string name);
    logic [15:0] v;
    rd(a, v);
    check(name, v, exp);
  endtask

  task automatic poll(input logic [12:0] a, input logic [15:0] mask, input logic [15:0] want,
                      input string name);
    logic [15:0] v;
    int n = 0;
    do begin
      rd(a, v);
      n++;
    end while ((v & mask) != want && n < 200);
    check(name, v & mask, want);
  endtask

  task automatic wait_ld_low(input string name);
    int n = 0;
    while (ld_tx_data && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, 16'(ld_tx_data), 16'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int r;
    int n;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("tx_enable_after_reset", 16'(tx_enable), 16'd1);
    rd_check(A_XCSR, 16'o000200, "xcsr_reset");
    rd_check(A_RCSR, 16'o000000, "rcsr_reset");
    rd_check(A_RBUF, 16'h0000, "rbuf_reset");

    // transmit 0x41; a second write mid-frame must be dropped
    wr(A_XBUF, 16'h0041, 1'b0);
    #1;
    check("ld_next_cycle", 16'(ld_tx_data), 16'd1);
    check("tx_data_41", 16'(tx_data), 16'h0041);
    rd_check(A_XCSR, 16'o000000, "xcsr_busy");
    wait_ld_low("ld_drops");
    wr(A_XBUF, 16'h0077, 1'b0);
    #1 check("midframe_write_dropped", 16'(tx_data), 16'h0041);
    poll(A_XCSR, 16'o000200, 16'o000200, "ready_after_frame");
    check("one_byte_sent", 16'(sent_q.size()), 16'd1);

    // loopback of 0x41 then 0x5A
    poll(A_RCSR, 16'o000200, 16'o000200, "done_41");
    rd_check(A_RBUF, 16'h0041, "rbuf_41");
    rd_check(A_RCSR, 16'o000000, "rcsr_cleared_41");
    wr(A_XBUF, 16'h005A, 1'b0);
    poll(A_RCSR, 16'o000200, 16'o000200, "done_5a");
    rd_check(A_RBUF, 16'h005A, "rbuf_5a");
    rd_check(A_RCSR, 16'o000000, "rcsr_cleared_5a");

    // overrun
    @(negedge clk) deliver_q.push_back(8'h11);
    poll(A_RCSR, 16'o000200, 16'o000200, "done_11");
    @(negedge clk) deliver_q.push_back(8'h22);
    repeat (40) @(negedge clk);
    rd_check(A_RBUF, 16'hC022, "rbuf_overrun");
    rd_check(A_RBUF, 16'h0022, "rbuf_ovr_cleared");
    rd_check(A_RCSR, 16'o000000, "rcsr_after_ovr");

    // byte writes: high byte ignored, low byte acts as a word write
    wr(A_XCSR | 13'd1, 16'h4040, 1'b1);
    rd_check(A_XCSR, 16'o000200, "xcsr_hibyte_ignored");
    wr(A_XCSR, 16'h0040, 1'b1);
    rd_check(A_XCSR, 16'o000300, "xcsr_lobyte_ie");
    wr(A_XCSR, 16'h0000, 1'b0);

`ifdef DL11_INTR_EN
    wr(A_XCSR, 16'o000100, 1'b0);
    @(negedge clk);
    check("tx_int_req_set", 16'(tx_int_req), 16'd1);
    tx_int_ack = 1'b1;
    @(negedge clk);
    tx_int_ack = 1'b0;
    check("tx_int_req_acked", 16'(tx_int_req), 16'd0);
    wr(A_RCSR, 16'o000100, 1'b0);
    @(negedge clk) deliver_q.push_back(8'h33);
    n = 0;
    while (!rx_int_req && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("rx_int_req_set", 16'(rx_int_req), 16'd1);
    rd_check(A_RBUF, 16'h0033, "rbuf_33");
    @(negedge clk);
    check("rx_int_req_cond_drop", 16'(rx_int_req), 16'd0);
`else
    wr(A_XCSR, 16'o000100, 1'b0);
    rd_check(A_XCSR, 16'o000300, "xcsr_ie_rw");
    tx_int_ack = 1'b1;
    @(negedge clk);
    tx_int_ack = 1'b0;
    check("tx_int_req_tied", 16'(tx_int_req), 16'd0);
`endif
    wr(A_XCSR, 16'h0000, 1'b0);
    wr(A_RCSR, 16'h0000, 1'b0);

    // reset during a transfer
    wr(A_XBUF, 16'h0099, 1'b0);
    wait_ld_low("ld_drops_99");
    iopage_addr = A_XCSR;
    #2 reset = 1'b1;
    #1;
    check("reset_data_out", data_out, 16'h0000);
    check("reset_ld", 16'(ld_tx_data), 16'd0);
    check("reset_enable", 16'(tx_enable), 16'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    rd_check(A_XCSR, 16'o000200, "xcsr_after_abort");
    rd_check(A_RBUF, 16'h0000, "rbuf_after_abort");

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      iopage_rd = 1'b0; iopage_wr = 1'b0; iopage_byte_op = 1'b0;
      data_in = 16'($urandom);
      r = int'($urandom_range(0, 99));
      if (r < 40) begin
        iopage_addr = 13'($urandom);
      end else if (r < 50) begin
        iopage_addr = A_XBUF; iopage_wr = 1'b1; iopage_byte_op = 1'($urandom);
      end else if (r < 60) begin
        iopage_addr = A_RBUF; iopage_rd = 1'b1;
      end else if (r < 75) begin
        iopage_addr = BASE + 13'(2 * $urandom_range(0, 3)) + 13'($urandom_range(0, 1));
        iopage_rd = 1'b1; iopage_byte_op = iopage_addr[0];
      end else if (r < 85) begin
        iopage_addr = ($urandom_range(0, 1) != 0) ? A_RCSR : A_XCSR;
        iopage_byte_op = 1'($urandom);
        if (iopage_byte_op && $urandom_range(0, 1) != 0) iopage_addr = iopage_addr | 13'd1;
        iopage_wr = 1'b1;
      end else if (r < 92) begin
        iopage_addr = 13'($urandom);
        iopage_rd = 1'($urandom); iopage_wr = !iopage_rd;
      end else begin
        iopage_addr = BASE + 13'($urandom_range(0, 7));
        iopage_byte_op = iopage_addr[0] | 1'($urandom);
        iopage_wr = 1'b1;
      end
      rx_int_ack = ($urandom_range(0, 7) == 0);
      tx_int_ack = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) deliver_q.push_back(8'($urandom));
    end
    @(negedge clk);
    iopage_rd = 1'b0; iopage_wr = 1'b0; iopage_byte_op = 1'b0;
    rx_int_ack = 1'b0; tx_int_ack = 1'b0;
    repeat (200) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dl11_console.md
# dl11_console

Bus-side register front end for the console serial line: a DL11-compatible register set (RCSR/RBUF/XCSR/XBUF) on the I/O page that drives the async `uart` block directly downstream. It loads transmit bytes into the UART and unloads received bytes from it. It also crosses the UART's `tx_empty`/`rx_empty` status from the txclk/rxclk domains into `clk`, and raises console interrupt requests.

## Interface
- `BASE`, 13'o17560, I/O-page offset of RCSR (word-aligned, 8-byte window).
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `iopage_addr`  in  13  I/O-page byte offset.
- `data_in`  in  16  write data.
- `data_out`  out  16  read data. Combinational; 0 when not decoded.
- `iopage_rd`  in  1  read strobe, one `clk` per access.
- `iopage_wr`  in  1  write strobe, one `clk` per access.
- `iopage_byte_op`  in  1  byte access. `iopage_addr[0]` selects the high byte.
- `decode`  out  1  combinational: `iopage_addr[12:3] == BASE[12:3]`.
- `ld_tx_data`  out  1  to UART; load `tx_data`.
- `tx_data`  out  8  to UART.
- `tx_empty`  in  1  from UART (txclk domain).
- `uld_rx_data`  out  1  to UART; unload the received byte.
- `rx_data`  in  8  from UART (rxclk domain).
- `rx_empty`  in  1  from UART (rxclk domain).
- `tx_enable`, `rx_enable`  out  1  to UART. Constant 1 after reset, 0 in reset.
- `rx_int_req`, `tx_int_req`  out  1  interrupt requests.
- `rx_int_ack`, `tx_int_ack`  in  1  interrupt acknowledges, one `clk` pulse.

## Operation
- Registers, offset from BASE:
  - +0 RCSR: bit7 DONE (RO), bit6 IE (RW), other bits read 0.
  - +2 RBUF (RO): [7:0] data, bit14 OVR, bit15 ERR (= OVR).
  - +4 XCSR: bit7 READY (RO), bit6 IE (RW), other bits read 0.
  - +6 XBUF: write [7:0] to transmit; reads return 0.
- Byte writes:
  - Writes to the high byte of RCSR, XCSR or XBUF are ignored.
  - A byte write to the low byte behaves like a word write of those 8 bits.
- Synchronizers: `tx_empty` and `rx_empty` each pass through a 2-flop synchronizer (`tx_e_s`, `rx_e_s`). The reset value of each flop is 1.
- TX FSM states: T_IDLE, T_LOAD, T_BUSY.
  - A write to XBUF while READY=1 latches `tx_data` and clears READY. The FSM goes T_IDLE→T_LOAD.
  - A write to XBUF while READY=0 is ignored: no latch, no state change.
  - T_LOAD: `ld_tx_data`=1 until `tx_e_s`=0, then →T_BUSY. Holding the strobe across several txclk edges is intentional; the UART latches only the first one.
  - T_BUSY: when `tx_e_s`=1 → T_IDLE and READY=1.
- RX FSM states: R_IDLE, R_UNLD, R_CAP.
  - R_IDLE: when `rx_e_s`=0 → R_UNLD.
  - R_UNLD: `uld_rx_data`=1 until `rx_e_s`=1, then →R_CAP.
  - R_CAP: RBUF[7:0] ← `rx_data`. If DONE=1 at that point, set OVR; otherwise leave OVR unchanged. Set DONE. → R_IDLE.
- An RBUF read (`iopage_rd` && decode && offset +2) clears DONE and OVR on that edge. `data_out` in that cycle shows the pre-clear values.
- A simultaneous R_CAP and RBUF read: capture wins, and DONE stays 1.

## Timing
- Reset values:
  - `data_out`=0, DONE=0, both IE=0, READY=1, OVR=0, RBUF=0.
  - `ld_tx_data`=0, `uld_rx_data`=0, `tx_data`=0, `*_int_req`=0, `*_enable`=0.
  - Both FSMs in their idle state.
- Reset mid-transfer aborts both FSMs. The UART is reset by the same net.
- XBUF write to `ld_tx_data` high: 1 `clk`.
- UART status change to FSM reaction: 2–3 `clk`.
- R_CAP lasts 1 cycle. `rx_data` has been stable for ≥2 `clk` by then, because the UART updates it on the same rxclk edge that sets `rx_empty`.
- Reads are combinational; side effects take place at the end of the read cycle.

## Configuration
- `DL11_INTR_EN` defined:
  - `rx_int_req` is set on the rising edge of (RCSR.IE & DONE).
  - `tx_int_req` is set on the rising edge of (XCSR.IE & READY).
  - Each request is cleared by its ack, or when its condition drops.
  - Setting IE while DONE or READY is already 1 counts as a rising edge.
- `DL11_INTR_EN` undefined:
  - Both requests are tied to 0 and the acks are ignored.
  - The IE bits remain read/write.

## Test plan
- Reset, then read +4 → 16'o000200; read +0 → 0; `tx_enable`=1 after reset deasserts.
- Word write 8'h41 to XBUF:
  - `ld_tx_data` rises the next cycle; `tx_data`=8'h41; READY=0.
  - After the UART frame completes, READY=1.
  - A second write issued mid-frame is dropped.
- UART loopback of 8'h5A:
  - DONE=1 and RBUF reads 16'h005A.
  - After the read, RCSR reads 0.
- Two frames received without reading RBUF → RBUF=16'hC000 | second byte; a read clears OVR.
- With `DL11_INTR_EN`:
  - Set XCSR.IE while idle → `tx_int_req`=1 within 1 cycle.
  - `tx_int_ack` → 0.
  - Receive a byte with RCSR.IE=1 → `rx_int_req`=1.
- Assert reset during T_BUSY → READY=1, `ld_tx_data`=0, `data_out`=0 immediately.
